// File: rtl/dimc_tile_seq_if.sv
// Config/status bundle between the CSR layer and the DIMC tile sequencer.
// master: drives abort, job config, stall overrides and per-tile buffer
//         flags; receives feat_en, tile_en, rcsn_rb, cg_en, busy, done,
//         stall_cnt.  slave: the sequencer side of the same signals.
interface dimc_tile_seq_if #(
   parameter int NUM_TILES   = 4,
   parameter int FEAT_CNT_W  = 8,
   parameter int RCSN_W      = 4,
   parameter int STALL_CNT_W = 16
);
   logic                   SOFT_RESET;
   logic                   start;
   logic [NUM_TILES-1:0]   tile_mask;
   logic [FEAT_CNT_W-1:0]  valid_feat_count;
   logic                   psout_mode;
   logic                   DISABLE_STALL;
   logic                   DISABLE_PS_STALL;
   logic                   DISABLE_SOUT_STALL;
   logic                   DISABLE_PSOUT_STALL;
   logic                   CG_DISABLE;
   logic [NUM_TILES-1:0]   feat_buff_empty;
   logic [NUM_TILES-1:0]   psin_buff_empty;
   logic [NUM_TILES-1:0]   sout_buff_full;
   logic [NUM_TILES-1:0]   psout_buff_full;
   logic                   feat_en;
   logic [NUM_TILES-1:0]   tile_en;
   logic [RCSN_W-1:0]      rcsn_rb;
   logic [NUM_TILES-1:0]   cg_en;
   logic                   busy;
   logic                   done;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output SOFT_RESET, start, tile_mask, valid_feat_count,
      output psout_mode, DISABLE_STALL, DISABLE_PS_STALL,
      output DISABLE_SOUT_STALL, DISABLE_PSOUT_STALL, CG_DISABLE,
      output feat_buff_empty, psin_buff_empty,
      output sout_buff_full, psout_buff_full,
      input  feat_en, tile_en, rcsn_rb, cg_en,
      input  busy, done, stall_cnt
   );

   modport slave (
      input  SOFT_RESET, start, tile_mask, valid_feat_count,
      input  psout_mode, DISABLE_STALL, DISABLE_PS_STALL,
      input  DISABLE_SOUT_STALL, DISABLE_PSOUT_STALL, CG_DISABLE,
      input  feat_buff_empty, psin_buff_empty,
      input  sout_buff_full, psout_buff_full,
      output feat_en, tile_en, rcsn_rb, cg_en,
      output busy, done, stall_cnt
   );
endinterface

// File: rtl/dimc_tile_seq.sv
// Multi-tile DIMC feature-issue sequencer: one start walks the enabled
// tiles in ascending order, issuing valid_feat_count beats per tile.
// Ports: dimc_tilewrap_clk (clock), resetn (async active-low reset),
// io (dimc_tile_seq_if.slave: job config, stall flags, beat/status out).
module dimc_tile_seq #(
   parameter int NUM_TILES    = 4,
   parameter int FEAT_CNT_W   = 8,
   parameter int RCSN_W       = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int STALL_CNT_W  = 16
) (
   input logic            dimc_tilewrap_clk,
   input logic            resetn,
   dimc_tile_seq_if.slave io
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   state_t                 state, state_n;
   logic [RCSN_W-1:0]      cur, cur_n;
   logic                   fin, fin_n;
   logic [FEAT_CNT_W-1:0]  bcnt, bcnt_n;
   logic [FEAT_CNT_W-1:0]  cnt_q, cnt_n;
   logic [NUM_TILES-1:0]   mask_q, mask_n;
   logic                   psm_q, psm_n;
   logic [DW-1:0]          dcnt, dcnt_n;
   logic                   feat_q, feat_n;
   logic                   busy_q, busy_n;
   logic                   done_q, done_n;
   logic [NUM_TILES-1:0]   ten_q, ten_n;
   logic [RCSN_W-1:0]      rcsn_q, rcsn_n;
   logic [STALL_CNT_W-1:0] scnt, scnt_n;
   logic [RCSN_W:0]        first, nxt;
   logic [NUM_TILES-1:0]   sel, blk;
   logic                   stall;

   // Lowest enabled tile at or above 'from'; MSB of result = found.
   function automatic logic [RCSN_W:0] find_tile(
      input logic [NUM_TILES-1:0] m,
      input int                   from
   );
      logic [RCSN_W:0] r;
      r = '0;
      for (int i = NUM_TILES - 1; i >= 0; i--)
         if (m[i] && i >= from) r = {1'b1, RCSN_W'(i)};
      return r;
   endfunction

   assign first = find_tile(mask_q, 0);
   assign nxt   = find_tile(mask_q, int'(cur) + 1);
   assign sel   = NUM_TILES'(1) << cur;

   // Per-tile stall vector; the current tile's bit is selected below.
   assign blk =
      (io.feat_buff_empty & {NUM_TILES{!io.DISABLE_STALL}})
    | (io.sout_buff_full & {NUM_TILES{!io.DISABLE_SOUT_STALL}})
    | ({NUM_TILES{psm_q}} &
       ((io.psin_buff_empty & {NUM_TILES{!io.DISABLE_PS_STALL}})
      | (io.psout_buff_full & {NUM_TILES{!io.DISABLE_PSOUT_STALL}})));
   assign stall = |(blk & sel);

   always_comb begin
      state_n = state;
      cur_n   = cur;
      fin_n   = fin;
      bcnt_n  = bcnt;
      cnt_n   = cnt_q;
      mask_n  = mask_q;
      psm_n   = psm_q;
      dcnt_n  = dcnt;
      scnt_n  = scnt;
      feat_n  = 1'b0;
      ten_n   = ten_q;
      rcsn_n  = rcsn_q;
      unique case (state)
         IDLE: if (io.start) begin
            state_n = LOAD;
            mask_n  = io.tile_mask;
            cnt_n   = io.valid_feat_count;
            psm_n   = io.psout_mode;
            scnt_n  = '0;
         end
         LOAD: begin
            fin_n  = 1'b0;
            bcnt_n = '0;
            dcnt_n = '0;
            if (first[RCSN_W] && cnt_q != '0) begin
               state_n = RUN;
               cur_n   = first[RCSN_W-1:0];
               ten_n   = NUM_TILES'(1) << first[RCSN_W-1:0];
               rcsn_n  = first[RCSN_W-1:0];
            end else begin
               state_n = DRAIN;
            end
         end
         RUN: begin
            // fin marks that the final beat is on the outputs now;
            // the next edge leaves RUN so that beat keeps its tile_en.
            if (fin) begin
               state_n = DRAIN;
               ten_n   = '0;
            end else if (stall) begin
               if (!(&scnt)) scnt_n = scnt + 1'b1;
            end else begin
               feat_n = 1'b1;
               ten_n  = sel;
               rcsn_n = cur;
               if (bcnt == cnt_q - 1'b1) begin
                  bcnt_n = '0;
                  if (nxt[RCSN_W]) cur_n = nxt[RCSN_W-1:0];
                  else fin_n = 1'b1;
               end else begin
                  bcnt_n = bcnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (dcnt == DW'(DRAIN_CYCLES - 1)) state_n = DONE;
            else dcnt_n = dcnt + 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (io.SOFT_RESET) begin
         state_n = IDLE;
         cur_n   = '0;
         fin_n   = 1'b0;
         bcnt_n  = '0;
         dcnt_n  = '0;
         scnt_n  = '0;
         feat_n  = 1'b0;
      end
      if (state_n == IDLE) begin
         rcsn_n = '0;
         ten_n  = '0;
      end
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge dimc_tilewrap_clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         cur    <= '0;
         fin    <= 1'b0;
         bcnt   <= '0;
         cnt_q  <= '0;
         mask_q <= '0;
         psm_q  <= 1'b0;
         dcnt   <= '0;
         scnt   <= '0;
         feat_q <= 1'b0;
         ten_q  <= '0;
         rcsn_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         cur    <= cur_n;
         fin    <= fin_n;
         bcnt   <= bcnt_n;
         cnt_q  <= cnt_n;
         mask_q <= mask_n;
         psm_q  <= psm_n;
         dcnt   <= dcnt_n;
         scnt   <= scnt_n;
         feat_q <= feat_n;
         ten_q  <= ten_n;
         rcsn_q <= rcsn_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   assign io.feat_en   = feat_q;
   assign io.tile_en   = ten_q;
   assign io.rcsn_rb   = rcsn_q;
   assign io.busy      = busy_q;
   assign io.done      = done_q;
   assign io.stall_cnt = scnt;
   assign io.cg_en     = ten_q | {NUM_TILES{io.CG_DISABLE}};
endmodule

// File: tb/tb_dimc_tile_seq.sv
// Directed bench for dimc_tile_seq (4 tiles, 4-bit stall counter).
// Ports: none; drives dimc_tile_seq_if and clock/reset.
module tb_dimc_tile_seq;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   s0 = 0;
   int   dc = 0;
   int   nbeat = 0;
   int   ndone = 0;
   int   nbusy = 0;
   int   cg_bad = 0;
   logic [3:0] br[$];
   logic [3:0] bt[$];
   int         bc[$];

   dimc_tile_seq_if #(
      .NUM_TILES(4), .FEAT_CNT_W(8), .RCSN_W(4), .STALL_CNT_W(4)
   ) io ();

   dimc_tile_seq #(
      .NUM_TILES(4), .FEAT_CNT_W(8), .RCSN_W(4),
      .DRAIN_CYCLES(4), .STALL_CNT_W(4)
   ) dut (
      .dimc_tilewrap_clk(clk),
      .resetn(resetn),
      .io(io)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (io.feat_en === 1'b1) begin
         br.push_back(io.rcsn_rb);
         bt.push_back(io.tile_en);
         bc.push_back(cyc);
         nbeat++;
      end
      if (io.done === 1'b1) ndone++;
      if (io.busy === 1'b1) nbusy++;
      if (io.cg_en !== (io.tile_en | {4{io.CG_DISABLE}})) cg_bad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      br.delete();
      bt.delete();
      bc.delete();
      nbeat = 0;
      ndone = 0;
      nbusy = 0;
   endtask

   function automatic logic [31:0] pack(input logic [3:0] q[$]);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = (v << 4) | 32'(q[i]);
      return v;
   endfunction

   // Inputs are scrambled after the start edge to prove they are latched.
   task automatic start_job(input logic [3:0] m,
                            input logic [7:0] c,
                            input logic p);
      io.tile_mask        = m;
      io.valid_feat_count = c;
      io.psout_mode       = p;
      io.start            = 1'b1;
      tick();
      io.start            = 1'b0;
      io.tile_mask        = ~m;
      io.valid_feat_count = c + 8'd5;
      io.psout_mode       = ~p;
      s0 = cyc;
   endtask

   task automatic wait_done(input string tag);
      dc = -1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (io.done === 1'b1) begin
            dc = cyc;
            break;
         end
      end
      chk(tag, 32'(dc >= 0), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_feat"}, io.feat_en, 1'b0);
      chk({tag, "_tile"}, io.tile_en, 4'h0);
      chk({tag, "_rcsn"}, io.rcsn_rb, 4'h0);
      chk({tag, "_busy"}, io.busy, 1'b0);
      chk({tag, "_done"}, io.done, 1'b0);
      chk({tag, "_scnt"}, io.stall_cnt, 4'h0);
   endtask

   initial begin
      io.SOFT_RESET          = 1'b0;
      io.start               = 1'b0;
      io.tile_mask           = '0;
      io.valid_feat_count    = '0;
      io.psout_mode          = 1'b0;
      io.DISABLE_STALL       = 1'b0;
      io.DISABLE_PS_STALL    = 1'b0;
      io.DISABLE_SOUT_STALL  = 1'b0;
      io.DISABLE_PSOUT_STALL = 1'b0;
      io.CG_DISABLE          = 1'b0;
      io.feat_buff_empty     = '0;
      io.psin_buff_empty     = '0;
      io.sout_buff_full      = '0;
      io.psout_buff_full     = '0;

      #12;
      chk_idle("rst");
      chk("rst_cg", io.cg_en, 4'h0);
      tick();
      resetn = 1'b1;
      tick();

      // Two tiles, three beats each, no stalls.
      clr();
      start_job(4'b0101, 8'd3, 1'b0);
      chk("t1_busy_e0", io.busy, 1'b1);
      chk("t1_feat_e0", io.feat_en, 1'b0);
      wait_done("t1_done_seen");
      chk("t1_done_cyc", 32'(dc - s0), 32'd12);
      chk("t1_tile_at_done", io.tile_en, 4'h0);
      chk("t1_rcsn_at_done", io.rcsn_rb, 4'h2);
      chk("t1_busy_at_done", io.busy, 1'b1);
      tick();
      chk("t1_nbeat", 32'(nbeat), 32'd6);
      chk("t1_rcsn_seq", pack(br), 32'h000222);
      chk("t1_tile_seq", pack(bt), 32'h111444);
      chk("t1_first_lat", 32'(bc[0] - s0), 32'd2);
      chk("t1_contig", 32'(bc[5] - bc[0]), 32'd5);
      chk("t1_done_gap", 32'(dc - bc[5]), 32'd5);
      chk("t1_ndone", 32'(ndone), 32'd1);
      chk("t1_scnt", io.stall_cnt, 4'h0);
      chk("t1_busy_after", io.busy, 1'b0);
      chk("t1_done_after", io.done, 1'b0);
      chk("t1_rcsn_after", io.rcsn_rb, 4'h0);

      // Tile 2 feature buffer empty for its first five decisions.
      clr();
      io.feat_buff_empty = 4'b0100;
      start_job(4'b0101, 8'd3, 1'b0);
      repeat (7) tick();
      chk("t2_hold_tile", io.tile_en, 4'b0001);
      chk("t2_hold_rcsn", io.rcsn_rb, 4'h0);
      chk("t2_hold_feat", io.feat_en, 1'b0);
      repeat (2) tick();
      io.feat_buff_empty = 4'b0000;
      wait_done("t2_done_seen");
      tick();
      chk("t2_nbeat", 32'(nbeat), 32'd6);
      chk("t2_rcsn_seq", pack(br), 32'h000222);
      chk("t2_pause", 32'(bc[3] - bc[2]), 32'd6);
      chk("t2_scnt", io.stall_cnt, 4'd5);

      // Same flag, stall class disabled: no pause.
      clr();
      io.DISABLE_STALL   = 1'b1;
      io.feat_buff_empty = 4'b0100;
      start_job(4'b0101, 8'd3, 1'b0);
      wait_done("t2d_done_seen");
      tick();
      chk("t2d_nbeat", 32'(nbeat), 32'd6);
      chk("t2d_contig", 32'(bc[5] - bc[0]), 32'd5);
      chk("t2d_scnt", io.stall_cnt, 4'd0);
      io.DISABLE_STALL   = 1'b0;
      io.feat_buff_empty = 4'b0000;

      // PSOUT-full stall active only under psout_mode.
      clr();
      io.psout_buff_full = 4'b0001;
      start_job(4'b0001, 8'd2, 1'b1);
      repeat (6) tick();
      chk("t3_nbeat_stalled", 32'(nbeat), 32'd0);
      chk("t3_scnt_stalled", io.stall_cnt, 4'd5);
      io.psout_buff_full = 4'b0000;
      wait_done("t3_done_seen");
      tick();
      chk("t3_nbeat", 32'(nbeat), 32'd2);
      chk("t3_done_gap", 32'(dc - bc[1]), 32'd5);
      chk("t3_scnt", io.stall_cnt, 4'd5);
      clr();
      io.psout_buff_full = 4'b0001;
      start_job(4'b0001, 8'd2, 1'b0);
      chk("t3n_scnt_clr", io.stall_cnt, 4'd0);
      wait_done("t3n_done_seen");
      tick();
      chk("t3n_nbeat", 32'(nbeat), 32'd2);
      chk("t3n_lat", 32'(bc[0] - s0), 32'd2);
      chk("t3n_scnt", io.stall_cnt, 4'd0);
      io.psout_buff_full = 4'b0000;

      // Empty jobs: mask zero, then count zero.
      clr();
      start_job(4'b0000, 8'd3, 1'b0);
      wait_done("t4m_done_seen");
      chk("t4m_done_cyc", 32'(dc - s0), 32'd5);
      tick();
      chk("t4m_nbeat", 32'(nbeat), 32'd0);
      chk("t4m_nbusy", 32'(nbusy), 32'd6);
      clr();
      start_job(4'b1111, 8'd0, 1'b0);
      wait_done("t4c_done_seen");
      chk("t4c_done_cyc", 32'(dc - s0), 32'd5);
      tick();
      chk("t4c_nbeat", 32'(nbeat), 32'd0);
      chk("t4c_nbusy", 32'(nbusy), 32'd6);

      // Held stall saturates; abort with start in the same cycle.
      clr();
      io.feat_buff_empty = 4'b0001;
      start_job(4'b0001, 8'd1, 1'b0);
      repeat (20) tick();
      chk("t5s_scnt_sat", io.stall_cnt, 4'hf);
      chk("t5s_tile", io.tile_en, 4'b0001);
      io.SOFT_RESET = 1'b1;
      io.start      = 1'b1;
      tick();
      chk_idle("t5s_abort");
      io.SOFT_RESET      = 1'b0;
      io.start           = 1'b0;
      io.feat_buff_empty = 4'b0000;
      repeat (10) tick();
      chk("t5s_ndone", 32'(ndone), 32'd0);
      chk("t5s_busy", io.busy, 1'b0);

      // Abort during beat 2.
      clr();
      start_job(4'b0101, 8'd3, 1'b0);
      repeat (3) tick();
      chk("t5b_beat2", io.feat_en, 1'b1);
      io.SOFT_RESET = 1'b1;
      io.start      = 1'b1;
      tick();
      chk_idle("t5b_abort");
      io.SOFT_RESET = 1'b0;
      io.start      = 1'b0;
      repeat (10) tick();
      chk("t5b_ndone", 32'(ndone), 32'd0);
      chk("t5b_nbeat", 32'(nbeat), 32'd2);
      chk("t5b_busy", io.busy, 1'b0);

      // Clean job after the abort.
      clr();
      start_job(4'b0010, 8'd2, 1'b0);
      wait_done("t5c_done_seen");
      tick();
      chk("t5c_nbeat", 32'(nbeat), 32'd2);
      chk("t5c_rcsn_seq", pack(br), 32'h11);
      chk("t5c_tile_seq", pack(bt), 32'h22);
      chk("t5c_ndone", 32'(ndone), 32'd1);

      // CG_DISABLE forcing, then async reset in DRAIN.
      clr();
      io.CG_DISABLE = 1'b1;
      start_job(4'b1000, 8'd1, 1'b0);
      chk("t6_cg_load", io.cg_en, 4'hf);
      repeat (2) tick();
      chk("t6_feat", io.feat_en, 1'b1);
      chk("t6_tile", io.tile_en, 4'b1000);
      chk("t6_rcsn", io.rcsn_rb, 4'h3);
      chk("t6_cg_run", io.cg_en, 4'hf);
      repeat (2) tick();
      chk("t6_drain_tile", io.tile_en, 4'h0);
      chk("t6_drain_rcsn", io.rcsn_rb, 4'h3);
      chk("t6_drain_busy", io.busy, 1'b1);
      #3;
      resetn = 1'b0;
      #1;
      chk_idle("t6_async");
      chk("t6_cg_async", io.cg_en, 4'hf);
      io.CG_DISABLE = 1'b0;
      #1;
      chk("t6_cg_off", io.cg_en, 4'h0);
      repeat (3) tick();
      resetn = 1'b1;
      repeat (10) tick();
      chk("t6_ndone", 32'(ndone), 32'd0);
      chk("t6_busy", io.busy, 1'b0);

      chk("cg_track", 32'(cg_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dimc_tile_seq.md
# dimc_tile_seq

Multi-tile DIMC feature-issue sequencer, successor to the single-tile DIMC tile-wrap control set. A single start steps through NUM_TILES tiles in ascending order and issues valid_feat_count feature beats per enabled tile. Each tile's beats are gated by that tile's own feature, PS-in, SOUT and PSOUT buffer flags, subject to the per-class stall disables. The block sits between the test or CSR configuration layer and the array of DIMC tile wrappers.

## Interface
- NUM_TILES, 4, number of tiles sequenced (1..16)
- FEAT_CNT_W, 8, width of valid_feat_count and the beat counter
- RCSN_W, 4, width of rcsn_rb; must satisfy 2^RCSN_W >= NUM_TILES
- DRAIN_CYCLES, 4, flush cycles after the last beat (>=1)
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- dimc_tilewrap_clk  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- SOFT_RESET  in  1  synchronous active-high abort
- start  in  1  one-cycle request; sampled only in IDLE
- tile_mask  in  NUM_TILES  tiles to process
- valid_feat_count  in  FEAT_CNT_W  beats per enabled tile
- psout_mode  in  1  enables PS-in/PSOUT stall checks
- DISABLE_STALL, DISABLE_PS_STALL, DISABLE_SOUT_STALL, DISABLE_PSOUT_STALL  in  1 each  per-class stall override
- CG_DISABLE  in  1  forces all cg_en high
- feat_buff_empty, psin_buff_empty, sout_buff_full, psout_buff_full  in  NUM_TILES each  per-tile buffer flags
- feat_en  out  1  one feature beat this cycle
- tile_en  out  NUM_TILES  one-hot current tile
- rcsn_rb  out  RCSN_W  binary index of current tile
- cg_en  out  NUM_TILES  per-tile clock enable
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- stall_cnt  out  STALL_CNT_W  stalled RUN cycles of the last job

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE -> LOAD on start. LOAD latches tile_mask, valid_feat_count and psout_mode, and clears stall_cnt. Input changes after LOAD have no effect on the job.
- LOAD -> RUN, pointing at the lowest enabled tile with count > 0. If none exists (mask==0 or count==0), LOAD -> DRAIN and no beats are issued.
- Stall for current tile t, evaluated in RUN. The stall is the OR of:
  - feat_buff_empty[t] & !DISABLE_STALL
  - sout_buff_full[t] & !DISABLE_SOUT_STALL
  - psout_mode & psin_buff_empty[t] & !DISABLE_PS_STALL
  - psout_mode & psout_buff_full[t] & !DISABLE_PSOUT_STALL
- Each RUN cycle without a stall issues one beat and increments the beat counter.
- Each RUN cycle with a stall increments stall_cnt, saturating at all-ones.
- After beat number valid_feat_count of tile t, the pointer advances to the next enabled tile with no bubble. After the last enabled tile, RUN -> DRAIN.
- DRAIN counts DRAIN_CYCLES cycles, then goes to DONE. DONE pulses done for one cycle, then returns to IDLE.
- start while busy is ignored.
- SOFT_RESET in any state forces IDLE next cycle, clears all counters, and drives all outputs to their reset values. SOFT_RESET has priority over start in the same cycle.
- cg_en = tile_en | {NUM_TILES{CG_DISABLE}}.

## Timing
- Reset values: feat_en=0, tile_en=0, rcsn_rb=0, busy=0, done=0, stall_cnt=0. cg_en=0 unless CG_DISABLE=1.
- All outputs are registered except cg_en, which is combinational from tile_en and CG_DISABLE.
- Start latency:
  - Edge E0 samples start; busy=1 after E0.
  - Edge E1 enters RUN.
  - The stall decision at edge E2 gives feat_en=1 in the cycle after E2, when there is no stall.
- feat_en, tile_en and rcsn_rb are registered together, so every beat carries the index of its own tile.
- tile_en and rcsn_rb hold their values between beats and across stalls. tile_en clears on entry to DRAIN; rcsn_rb holds its last value until IDLE.
- Stall flags are sampled at the edge. A flag dropping at edge Ek allows a beat in the cycle after Ek.
- done is high exactly one cycle, DRAIN_CYCLES+1 cycles after the last feat_en cycle. busy falls in the same cycle done falls.
- Asynchronous resetn mid-job returns every output to its reset value immediately, with no completion pulse.

## Test plan
- mask=4'b0101, count=3, no stalls -> 6 consecutive feat_en cycles, rcsn_rb=0,0,0,2,2,2, tile_en=0001 then 0100, done once, stall_cnt=0.
- Same job with feat_buff_empty[2] high for 5 cycles at tile 2's first beat -> beats pause 5 cycles, stall_cnt=5. Repeating with DISABLE_STALL=1 -> no pause, stall_cnt=0.
- psout_mode=1, psout_buff_full[0]=1, count=2 -> no beats, stall_cnt increments. Releasing the flag -> 2 beats and done. With psout_mode=0 the flag is ignored.
- mask=0 or count=0 -> zero feat_en, done high DRAIN_CYCLES+1 cycles after LOAD, busy for LOAD+DRAIN+DONE only.
- SOFT_RESET during RUN beat 2, then a second start in the same cycle -> IDLE, outputs zero, no done, start ignored. A new start afterwards runs cleanly. A held stall with STALL_CNT_W=4 saturates stall_cnt at 15.
- resetn low mid-DRAIN -> all outputs 0 asynchronously, no done pulse. CG_DISABLE=1 -> cg_en all ones throughout.
